countdown_ctrl: RTL



---
 rtl/countdown_ctrl_if.sv | 31 +++
 rtl/countdown_ctrl.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/countdown_ctrl_if.sv
// Signal bundle between the countdown controller and its surroundings
// (button debouncers, tick generator, down counter, display mux).
interface countdown_ctrl_if;
  logic       tick;
  logic       btn_start;
  logic       btn_set;
  logic       btn_inc;
  logic [3:0] cnt0;
  logic [3:0] cnt1;
  logic [3:0] cnt2;
  logic [3:0] cnt3;
  logic [1:0] set;
  logic       switch;
  logic [3:0] in0;
  logic [3:0] in1;
  logic [3:0] in2;
  logic [3:0] in3;
  logic       alarm;
  logic [1:0] edit;
  logic       busy;

  modport master (
    input  tick, btn_start, btn_set, btn_inc, cnt0, cnt1, cnt2, cnt3,
    output set, switch, in0, in1, in2, in3, alarm, edit, busy
  );

  modport slave (
    output tick, btn_start, btn_set, btn_inc, cnt0, cnt1, cnt2, cnt3,
    input  set, switch, in0, in1, in2, in3, alarm, edit, busy
  );
endinterface

// File: rtl/countdown_ctrl.sv
// Control FSM for the MM:SS BCD countdown timer: preset editing, load, run/pause, alarm.
// Optional macro AUTO_RELOAD_EN: on expiry, reload the preset and keep counting instead of alarming.
module countdown_ctrl #(
  parameter int unsigned ALARM_TICKS = 10
) (
  input logic             clk,
  input logic             rst_n,
  countdown_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    SET_MIN,
    SET_SEC,
    LOAD,
    RUN,
    PAUSE,
    DONE
  } state_t;

  state_t     state, state_next;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [3:0] min_tens_next, min_ones_next, sec_tens_next, sec_ones_next;
  logic [7:0] alarm_cnt, alarm_cnt_next;
  logic       reload_flag, reload_next;
  logic       preset_zero;
  logic       cnt_zero;

  assign preset_zero = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                       (sec_tens == 4'd0) && (sec_ones == 4'd0);
  assign cnt_zero    = (bus.cnt3 == 4'd0) && (bus.cnt2 == 4'd0) &&
                       (bus.cnt1 == 4'd0) && (bus.cnt0 == 4'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      min_tens    <= 4'd0;
      min_ones    <= 4'd0;
      sec_tens    <= 4'd0;
      sec_ones    <= 4'd0;
      alarm_cnt   <= 8'd0;
      reload_flag <= 1'b0;
    end else begin
      state       <= state_next;
      min_tens    <= min_tens_next;
      min_ones    <= min_ones_next;
      sec_tens    <= sec_tens_next;
      sec_ones    <= sec_ones_next;
      alarm_cnt   <= alarm_cnt_next;
      reload_flag <= reload_next;
    end
  end

  always_comb begin
    state_next     = state;
    min_tens_next  = min_tens;
    min_ones_next  = min_ones;
    sec_tens_next  = sec_tens;
    sec_ones_next  = sec_ones;
    alarm_cnt_next = alarm_cnt;
    reload_next    = 1'b0;

    case (state)
      IDLE: begin
        if (bus.btn_set)
          state_next = SET_MIN;
        else if (bus.btn_start && !preset_zero)
          state_next = LOAD;
      end

      SET_MIN: begin
        if (bus.btn_inc) begin
          if (min_ones == 4'd9) begin
            min_ones_next = 4'd0;
            min_tens_next = (min_tens == 4'd9) ? 4'd0 : min_tens + 4'd1;
          end else begin
            min_ones_next = min_ones + 4'd1;
          end
        end
        if (bus.btn_set)
          state_next = SET_SEC;
      end

      SET_SEC: begin
        // Seconds wrap at 59, so the tens digit tops out at 5.
        if (bus.btn_inc) begin
          if (sec_ones == 4'd9) begin
            sec_ones_next = 4'd0;
            sec_tens_next = (sec_tens == 4'd5) ? 4'd0 : sec_tens + 4'd1;
          end else begin
            sec_ones_next = sec_ones + 4'd1;
          end
        end
        if (bus.btn_set)
          state_next = IDLE;
      end

      LOAD: begin
        state_next = RUN;
      end

      RUN: begin
        // Counter digits are registered, so zero shows up one cycle after the last decrement.
        if (cnt_zero) begin
`ifdef AUTO_RELOAD_EN
          state_next  = LOAD;
          reload_next = 1'b1;
`else
          state_next     = DONE;
          alarm_cnt_next = 8'd0;
`endif
        end else if (bus.btn_start) begin
          state_next = PAUSE;
        end
      end

      PAUSE: begin
        if (bus.btn_set)
          state_next = IDLE;
        else if (bus.btn_start)
          state_next = RUN;
      end

      DONE: begin
        if (bus.btn_start || bus.btn_set) begin
          state_next = IDLE;
        end else if (bus.tick) begin
          alarm_cnt_next = alarm_cnt + 8'd1;
          if (alarm_cnt + 8'd1 == 8'(ALARM_TICKS))
            state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign bus.set    = (state == LOAD) ? 2'b01 : 2'b00;
  assign bus.switch = bus.tick && (state == RUN);
  assign bus.in0    = sec_ones;
  assign bus.in1    = sec_tens;
  assign bus.in2    = min_ones;
  assign bus.in3    = min_tens;
  assign bus.alarm  = (state == DONE) || reload_flag;
  assign bus.edit   = (state == SET_MIN) ? 2'b01 :
                      (state == SET_SEC) ? 2'b10 : 2'b00;
  assign bus.busy   = (state == LOAD) || (state == RUN) || (state == PAUSE);

endmodule
